ps2_pkt_ctrl: RTL and testbench
===============================

Name: ps2_pkt_ctrl

Overview:
Receive-side controller for the PS/2 mouse byte stream.
- Accepts bytes from the PS/2 deserializer and frames them into 3-byte packets. Byte 1 is identified by bit[3]=1.
- Buffers complete packets in a small FIFO and hands them to the host with a valid/ready handshake.
- Sits between the PS/2 bit-level receiver and the host register/interrupt block. It owns resynchronisation and drop accounting.

Parameters:
FIFO_DEPTH, 2, packet FIFO entries; power of 2, minimum 2.
CNT_W, 8, width of the saturating dropped-packet counter.
TIMEOUT_CYCLES, 1000, idle clocks mid-packet before forced resync (used only when PS2_PKT_TIMEOUT_EN is defined); minimum 2.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
byte_valid  input  1  one-cycle strobe: byte_data holds a received byte.
byte_data  input  8  received PS/2 byte.
pkt_valid  output  1  FIFO non-empty; head packet presented.
pkt_ready  input  1  host accepts head packet when pkt_valid=1.
pkt_data  output  24  head packet {byte1,byte2,byte3}; byte1 in [23:16].
fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
drop_cnt  output  CNT_W  packets lost to FIFO-full; saturates at all-ones.
sync_lost  output  1  one-cycle pulse on a discarded byte or a timeout.

Behaviour:
- Reset (async assert, sync release): FSM=WAIT_B1, FIFO empty, all storage 0. Outputs: pkt_valid=0, pkt_data=0, fifo_level=0, drop_cnt=0, sync_lost=0.
- FSM states: WAIT_B1, WAIT_B2, WAIT_B3. Transitions occur only on cycles with byte_valid=1, except timeout.
  - WAIT_B1: if byte_data[3]=1, latch b1 and go to WAIT_B2. Else discard the byte, pulse sync_lost next cycle, stay in WAIT_B1.
  - WAIT_B2: latch b2, go to WAIT_B3. No bit[3] check.
  - WAIT_B3: assemble {b1,b2,byte_data} and attempt a FIFO push at the same edge, then go to WAIT_B1.
- Push/latency: the packet is written at the edge that accepts byte 3. When the FIFO was empty, pkt_valid=1 and pkt_data are valid on the following cycle (latency 1).
- Pop: occurs at an edge where pkt_valid & pkt_ready. The head advances; pkt_valid deasserts next cycle if the FIFO becomes empty.
- pkt_data and pkt_valid are registered/head-of-FIFO. pkt_data is stable while pkt_valid=1 and pkt_ready=0. pkt_data is don't-care while pkt_valid=0.
- Full:
  - Push while full with no pop: the packet is dropped, FIFO unchanged, drop_cnt+1 (saturating at 2^CNT_W-1).
  - Push while full with a simultaneous pop: the push succeeds, fifo_level stays FIFO_DEPTH, nothing is dropped.
- Empty: pkt_ready while empty has no effect.
- Simultaneous push and pop on a non-full, non-empty FIFO: fifo_level unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_level never exceeds FIFO_DEPTH.
- byte_valid is ignored during reset. An asynchronous reset mid-packet discards partial bytes and FIFO contents.
- sync_lost asserts for exactly one cycle per event. Back-to-back discarded bytes give back-to-back pulses.

Optional Feature:
PS2_PKT_TIMEOUT_EN
- Defined:
  - A counter runs while the FSM is in WAIT_B2 or WAIT_B3. It clears on every byte_valid and on entry to WAIT_B1.
  - After TIMEOUT_CYCLES consecutive cycles without byte_valid, the FSM returns to WAIT_B1. Latched partial bytes are discarded and sync_lost pulses once.
  - If byte_valid coincides with the expiry cycle, the byte is processed normally and no timeout occurs.
- Not defined: no counter logic. A partial packet waits indefinitely. sync_lost is caused only by bit[3] discards.

Decomposition:
- Package ps2_pkg holds:
  - the FSM state enum (WAIT_B1/WAIT_B2/WAIT_B3)
  - PS2_BYTE_W=8, PS2_PKT_W=24, PS2_SYNC_BIT=3
  - the packet struct {b1,b2,b3}
- One sub-module: ps2_pkt_fifo, a synchronous FIFO with push/pop/full/empty/level. It supports same-edge push-on-full-with-pop.
- The framing FSM, drop counter and timeout stay in ps2_pkt_ctrl.

Test Plan:
- Bytes 0x08,0x12,0x34 with pkt_ready=1 -> next cycle pkt_valid=1, pkt_data=0x081234; pop, fifo_level back to 0.
- Bytes 0x00,0x05,0x09,0x11,0x22 -> sync_lost pulses twice (for 0x00 and 0x05); one packet 0x091122.
- FIFO_DEPTH=2, pkt_ready=0, three valid packets -> fifo_level=2, drop_cnt=1, head remains packet 1. Repeat with pkt_ready=1 on the 3rd push edge -> drop_cnt unchanged, level 2.
- drop_cnt at 0xFF plus one more dropped packet -> stays 0xFF.
- reset_n low after 0x08,0x12 then released, then 0x18,0xAA,0xBB -> packet 0x18AABB only; no stale bytes.
- PS2_PKT_TIMEOUT_EN, TIMEOUT_CYCLES=10: 0x08, gap of 10 cycles, then 0x28,0x01,0x02 -> one sync_lost, packet 0x280102. With gap 9 instead -> no timeout; packet 0x082801, and 0x02 is discarded.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse packet receive path.
package ps2_pkg;

  localparam int PS2_BYTE_W   = 8;
  localparam int PS2_PKT_W    = 24;
  localparam int PS2_SYNC_BIT = 3;

  typedef enum logic [1:0] {
    WAIT_B1,
    WAIT_B2,
    WAIT_B3
  } state_t;

  typedef struct packed {
    logic [PS2_BYTE_W-1:0] b1;
    logic [PS2_BYTE_W-1:0] b2;
    logic [PS2_BYTE_W-1:0] b3;
  } pkt_t;

endpackage

// File: rtl/ps2_pkt_fifo.sv
// Synchronous packet FIFO, head presented combinationally from storage.
// A push while full is accepted when a pop happens at the same edge.
module ps2_pkt_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 24,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  // Pointers rely on DEPTH being a power of two so they wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ps2_pkt_ctrl.sv
// Frames PS/2 mouse bytes into 3-byte packets, queues them for the host, counts drops.
// Optional mid-packet idle resync enabled by defining PS2_PKT_TIMEOUT_EN.
module ps2_pkt_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 2,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          byte_valid,
  input  logic [PS2_BYTE_W-1:0]         byte_data,
  output logic                          pkt_valid,
  input  logic                          pkt_ready,
  output logic [PS2_PKT_W-1:0]          pkt_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic                          sync_lost
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("ps2_pkt_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
  end

  state_t                state;
  state_t                state_nxt;
  logic [PS2_BYTE_W-1:0] b1;
  logic [PS2_BYTE_W-1:0] b2;
  logic                  b1_ld;
  logic                  b2_ld;
  logic                  push_req;
  logic                  discard;
  logic                  tmo_hit;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  drop;
  pkt_t                  pkt;

  always_comb begin
    state_nxt = state;
    b1_ld     = 1'b0;
    b2_ld     = 1'b0;
    push_req  = 1'b0;
    discard   = 1'b0;
    if (byte_valid) begin
      case (state)
        WAIT_B1: begin
          if (byte_data[PS2_SYNC_BIT]) begin
            b1_ld     = 1'b1;
            state_nxt = WAIT_B2;
          end else begin
            discard = 1'b1;
          end
        end
        WAIT_B2: begin
          b2_ld     = 1'b1;
          state_nxt = WAIT_B3;
        end
        WAIT_B3: begin
          push_req  = 1'b1;
          state_nxt = WAIT_B1;
        end
        default: state_nxt = WAIT_B1;
      endcase
    end else if (tmo_hit) begin
      state_nxt = WAIT_B1;
    end
  end

`ifdef PS2_PKT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt;

  // tmo_cnt holds the number of idle cycles already spent mid-packet.
  assign tmo_hit = (state != WAIT_B1) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (byte_valid || state == WAIT_B1 || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_B1;
      b1        <= '0;
      b2        <= '0;
      sync_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      sync_lost <= discard || (tmo_hit && !byte_valid);
      if (b1_ld) b1 <= byte_data;
      if (b2_ld) b2 <= byte_data;
    end
  end

  assign pkt       = '{b1: b1, b2: b2, b3: byte_data};
  assign pkt_valid = !fifo_empty;
  assign pop       = pkt_valid && pkt_ready;
  // Full implies non-empty, so pkt_ready alone decides whether a slot frees up.
  assign drop      = push_req && fifo_full && !pkt_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  ps2_pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PS2_PKT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .din     (pkt),
    .pop     (pop),
    .dout    (pkt_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_ps2_pkt_ctrl.sv
// Directed bench for ps2_pkt_ctrl with a queue-based reference model checked every cycle.
module tb_ps2_pkt_ctrl;

  localparam int DEPTH = 2;
  localparam int CW    = 8;
  localparam int TMO   = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        pkt_ready = 1'b0;
  logic        pkt_valid;
  logic [23:0] pkt_data;
  logic [1:0]  fifo_level;
  logic [7:0]  drop_cnt;
  logic        sync_lost;

  int checks = 0;
  int errors = 0;
  int sync_seen = 0;
  bit run = 1'b0;

  ps2_pkt_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_data   (pkt_data),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt),
    .sync_lost  (sync_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: partial bytes and queued packets as plain queues.
  logic [7:0]  part[$];
  logic [23:0] mq[$];
  int          m_drop = 0;
  bit          m_sync = 1'b0;
  int          idle = 0;

  always @(posedge clk or negedge reset_n) begin : model
    bit          have;
    logic [23:0] np;
    if (!reset_n) begin
      part.delete();
      mq.delete();
      m_drop = 0;
      m_sync = 1'b0;
      idle   = 0;
    end else begin
      have   = 1'b0;
      np     = '0;
      m_sync = 1'b0;
      if (byte_valid) begin
        idle = 0;
        if (part.size() == 0 && !byte_data[3]) m_sync = 1'b1;
        else part.push_back(byte_data);
        if (part.size() == 3) begin
          np = {part[0], part[1], part[2]};
          part.delete();
          have = 1'b1;
        end
      end
`ifdef PS2_PKT_TIMEOUT_EN
      else if (part.size() != 0) begin
        idle++;
        if (idle == TMO) begin
          part.delete();
          m_sync = 1'b1;
          idle   = 0;
        end
      end
`endif
      if (pkt_ready && mq.size() != 0) void'(mq.pop_front());
      if (have) begin
        if (mq.size() < DEPTH) mq.push_back(np);
        else if (m_drop < (1 << CW) - 1) m_drop++;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("valid", 32'(pkt_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("data", 32'(pkt_data), 32'(mq[0]));
      chk("level", 32'(fifo_level), 32'(mq.size()));
      chk("drop", 32'(drop_cnt), 32'(m_drop));
      chk("sync", 32'(sync_lost), 32'(m_sync));
      if (sync_lost) sync_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a);
    send(b);
    send(c);
  endtask

  int s0;

  initial begin
    #1 reset_n = 1'b0;
    #1 run = 1'b1;
    repeat (3) step();
    chk("rst_valid", 32'(pkt_valid), 0);
    chk("rst_data", 32'(pkt_data), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_sync", 32'(sync_lost), 0);
    reset_n = 1'b1;
    step();

    // Basic packet, latency 1, then popped.
    pkt_ready = 1'b1;
    send_pkt(8'h08, 8'h12, 8'h34);
    chk("t1_valid", 32'(pkt_valid), 1);
    chk("t1_data", 32'(pkt_data), 32'h081234);
    chk("t1_level", 32'(fifo_level), 1);
    step();
    chk("t1_drained", 32'(fifo_level), 0);

    // Two discarded bytes before a good packet.
    s0 = sync_seen;
    send(8'h00);
    send(8'h05);
    send_pkt(8'h09, 8'h11, 8'h22);
    chk("t2_data", 32'(pkt_data), 32'h091122);
    step();
    chk("t2_sync_cnt", 32'(sync_seen - s0), 2);

    // Full FIFO drops the third packet.
    pkt_ready = 1'b0;
    send_pkt(8'h08, 8'h01, 8'h01);
    send_pkt(8'h08, 8'h02, 8'h02);
    send_pkt(8'h08, 8'h03, 8'h03);
    chk("t3_level", 32'(fifo_level), 2);
    chk("t3_drop", 32'(drop_cnt), 1);
    chk("t3_head", 32'(pkt_data), 32'h080101);
    pkt_ready = 1'b1;
    repeat (2) step();
    chk("t3_drained", 32'(fifo_level), 0);

    // Push on full with simultaneous pop succeeds.
    pkt_ready = 1'b0;
    send_pkt(8'h08, 8'h04, 8'h04);
    send_pkt(8'h08, 8'h05, 8'h05);
    send(8'h08);
    send(8'h06);
    pkt_ready = 1'b1;
    send(8'h06);
    pkt_ready = 1'b0;
    chk("t4_level", 32'(fifo_level), 2);
    chk("t4_drop", 32'(drop_cnt), 1);
    chk("t4_head", 32'(pkt_data), 32'h080505);
    pkt_ready = 1'b1;
    repeat (2) step();

    // Drop counter saturation: 2 fill + 254 drops reaches 0xFF.
    pkt_ready = 1'b0;
    repeat (256) send_pkt(8'h08, 8'h07, 8'h07);
    chk("t5_drop_max", 32'(drop_cnt), 32'hFF);
    send_pkt(8'h08, 8'h07, 8'h07);
    chk("t5_drop_sat", 32'(drop_cnt), 32'hFF);
    chk("t5_level", 32'(fifo_level), 2);
    pkt_ready = 1'b1;
    repeat (2) step();

    // Reset mid-packet discards partial bytes.
    pkt_ready = 1'b0;
    send(8'h08);
    send(8'h12);
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    chk("t6_level0", 32'(fifo_level), 0);
    chk("t6_drop0", 32'(drop_cnt), 0);
    send_pkt(8'h18, 8'hAA, 8'hBB);
    chk("t6_data", 32'(pkt_data), 32'h18AABB);
    chk("t6_level", 32'(fifo_level), 1);
    pkt_ready = 1'b1;
    step();
    chk("t6_drained", 32'(fifo_level), 0);

    // Gap of TIMEOUT_CYCLES idle cycles mid-packet.
    pkt_ready = 1'b0;
    s0 = sync_seen;
    send(8'h08);
    repeat (10) step();
    send_pkt(8'h28, 8'h01, 8'h02);
    step();
`ifdef PS2_PKT_TIMEOUT_EN
    chk("t7_data", 32'(pkt_data), 32'h280102);
`else
    chk("t7_data", 32'(pkt_data), 32'h082801);
`endif
    chk("t7_level", 32'(fifo_level), 1);
    chk("t7_sync_cnt", 32'(sync_seen - s0), 1);
    pkt_ready = 1'b1;
    step();

    // Gap one short of the timeout: no resync, trailing byte discarded.
    pkt_ready = 1'b0;
    s0 = sync_seen;
    send(8'h08);
    repeat (9) step();
    send_pkt(8'h28, 8'h01, 8'h02);
    step();
    chk("t8_data", 32'(pkt_data), 32'h082801);
    chk("t8_level", 32'(fifo_level), 1);
    chk("t8_sync_cnt", 32'(sync_seen - s0), 1);
    pkt_ready = 1'b1;
    repeat (2) step();

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
